pipe_stage_reg: RTL and testbench

Parametrised pipeline-stage register: the generalised successor of the fixed EX/MEM latch. It carries an opaque payload plus a vector of write-enable control bits from one stage to the next, with valid/ready flow control, stall, flush-to-bubble and an optional skid entry. A saturating stall counter supports performance analysis. One instance sits at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB); per-stage field packing is done by the instantiating stage.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_stage_reg_entry.sv | 22 ++
 rtl/pipe_stage_reg.sv | 153 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage-boundary registers.
// Holds per-boundary payload widths, the write-enable bit positions within
// the control vector, and the stage occupancy state encoding.
package pipe_pkg;

  // Control vector width shared by every stage boundary.
  localparam int PIPE_CTRL_W  = 4;

  // Per-boundary payload widths, after packing by the instantiating stage.
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_DATA_W  = 128;
  localparam int EXMEM_DATA_W = 128;
  localparam int MEMWB_DATA_W = 96;

  // Bit positions of the write enables inside ctrl.
  localparam int CTL_DMEM_WE  = 0;
  localparam int CTL_RF_WE    = 1;
  localparam int CTL_HI_WE    = 2;
  localparam int CTL_LO_WE    = 3;

  // Stage occupancy: nothing held, main entry held, main and skid held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// pipe_skid_entry: load-enabled W-bit register with async active-high reset.
// Ports: clk, rst, load (capture d this edge), d (next value), q (held value).
// Used for both the main and the skid entry of a pipeline stage register.
module pipe_skid_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush-to-bubble,
// optional skid entry (registered in_ready) and a saturating stall counter.
// Ports: in_* upstream side, out_* downstream side, flush, stall_cnt/stall_clr.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 4,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  localparam int ENT_W = CTRL_W + DATA_W;

  localparam logic [1:0] S_EMPTY = ST_EMPTY;
  localparam logic [1:0] S_MAIN  = ST_MAIN;
  localparam logic [1:0] S_FULL  = ST_FULL;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              accept;
  logic              drain;
  logic              main_ld;
  logic              skid_ld;
  logic              main_from_skid;
  logic [ENT_W-1:0]  in_ent;
  logic [ENT_W-1:0]  main_d;
  logic [ENT_W-1:0]  main_q;
  logic [ENT_W-1:0]  skid_q;
  logic [CTRL_W-1:0] main_ctrl;

  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign out_valid = (state != S_EMPTY);
  assign in_ent    = {in_ctrl, in_data};

  always_comb begin
    state_nxt      = state;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      // Flush drops everything held and any transfer arriving this edge.
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            state_nxt = S_MAIN;
            main_ld   = 1'b1;
          end
        end
        S_MAIN: begin
          if (accept && drain) begin
            main_ld = 1'b1;
          end else if (accept) begin
            // Only reachable with a skid entry: single-entry in_ready is
            // low whenever main is held and not draining.
            if (SKID != 0) begin
              state_nxt = S_FULL;
              skid_ld   = 1'b1;
            end else begin
              main_ld = 1'b1;
            end
          end else if (drain) begin
            state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (drain) begin
            state_nxt      = S_MAIN;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_ent;

  pipe_skid_entry #(.W(ENT_W)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_ld),
    .d    (main_d),
    .q    (main_q)
  );

  pipe_skid_entry #(.W(ENT_W)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_ld),
    .d    (in_ent),
    .q    (skid_q)
  );

  assign main_ctrl = main_q[ENT_W-1:DATA_W];
  assign out_data  = main_q[DATA_W-1:0];
  // A bubble must never present a write enable to the next stage.
  assign out_ctrl  = main_ctrl & {CTRL_W{out_valid}};

  generate
    if (SKID != 0) begin : g_reg_ready
      logic ready_q;
      // Registered ready breaks the combinational out_ready -> in_ready path.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_nxt != S_FULL);
        end
      end
      assign in_ready = ready_q;
    end else begin : g_comb_ready
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a SKID=1/CNT_W=4 instance for the
// streaming, backpressure, flush, bubble, saturation and async-reset
// scenarios, plus a SKID=0 instance for the combinational-ready variant.
module tb_pipe_stage_reg;

  localparam int DW = 8;
  localparam int CW = 4;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, flush, out_valid, out_ready, stall_clr;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [NW-1:0] stall_cnt;

  logic          v0, r0, ov0, or0;
  logic [CW-1:0] c0, oc0;
  logic [DW-1:0] d0, od0;
  logic [NW-1:0] sc0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0),
    .in_ctrl(c0), .in_data(d0), .flush(1'b0),
    .out_valid(ov0), .out_ready(or0), .out_ctrl(oc0),
    .out_data(od0), .stall_cnt(sc0), .stall_clr(1'b0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0;
    out_ready = 1'b1; stall_clr = 1'b0;
    v0 = 1'b0; c0 = '0; d0 = '0; or0 = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ctrl",  32'(out_ctrl),  32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst0_in_ready", 32'(r0),        32'd1);
    rst = 1'b0;
    tick();

    // Stream 1..8 with ctrl 1010, one cycle behind, in_ready constant 1
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_ctrl = 4'b1010; in_data = 8'(i);
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_data",  32'(out_data),  32'(i));
      chk("stream_ctrl",  32'(out_ctrl),  32'hA);
      chk("stream_ready", 32'(in_ready),  32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_valid", 32'(out_valid), 32'd0);
    chk("stream_end_ctrl",  32'(out_ctrl),  32'd0);

    // Backpressure: first beat lands, then 3 stall cycles with input pending
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    chk("bp_first", 32'(out_data), 32'h11);
    out_ready = 1'b0; in_data = 8'h12;
    tick();
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_data",  32'(out_data), 32'h11);
    in_data = 8'h13;
    tick();
    tick();
    chk("bp_stall_cnt",  32'(stall_cnt), 32'd3);
    chk("bp_still_full", 32'(in_ready),  32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_skid_out",   32'(out_data), 32'h12);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    tick();
    chk("bp_third_out",  32'(out_data),  32'h13);
    chk("bp_third_vld",  32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_drained",    32'(out_valid), 32'd0);
    chk("bp_cnt_hold",   32'(stall_cnt), 32'd3);

    // Flush while FULL with 0xAA offered on the input
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h21; in_ctrl = 4'hF;
    tick();
    in_data = 8'h22;
    tick();
    chk("fl_full", 32'(in_ready), 32'd0);
    flush = 1'b1; in_data = 8'hAA;
    #1;
    chk("fl_ready_same_cycle", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_out_ctrl",  32'(out_ctrl),  32'd0);
    chk("fl_in_ready",  32'(in_ready),  32'd1);
    chk("fl_data_kept", 32'(out_data),  32'h21);
    chk("fl_cnt_kept",  32'(stall_cnt), 32'd5);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_aa", 32'(out_valid), 32'd0);
    end

    // Bubble gating: idle with all enables on the input
    in_ctrl = 4'hF; in_data = 8'h55;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bubble_ctrl", 32'(out_ctrl), 32'd0);
    end

    // Counter saturation at 15, clear priority
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    chk("sat_clr0", 32'(stall_cnt), 32'd0);
    in_valid = 1'b1; in_data = 8'h31; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_15", 32'(stall_cnt), 32'd15);
    stall_clr = 1'b1;
    tick();
    chk("sat_clr", 32'(stall_cnt), 32'd0);
    stall_clr = 1'b0;
    tick();
    chk("sat_restart", 32'(stall_cnt), 32'd1);

    // Async reset mid-cycle while FULL
    in_valid = 1'b1; in_data = 8'h32;
    tick();
    in_valid = 1'b0;
    chk("ar_full", 32'(in_ready), 32'd0);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_out_ctrl",  32'(out_ctrl),  32'd0);
    chk("ar_out_data",  32'(out_data),  32'd0);
    chk("ar_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("ar_in_ready",  32'(in_ready),  32'd1);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    tick();
    chk("ar_no_partial", 32'(out_valid), 32'd0);

    // SKID=0 variant: combinational ready, overwrite on accept-and-drain
    or0 = 1'b0; v0 = 1'b1; d0 = 8'h41; c0 = 4'h3;
    tick();
    v0 = 1'b0;
    chk("s0_valid", 32'(ov0), 32'd1);
    chk("s0_data",  32'(od0), 32'h41);
    chk("s0_ctrl",  32'(oc0), 32'h3);
    chk("s0_stalled_ready", 32'(r0), 32'd0);
    or0 = 1'b1;
    #1;
    chk("s0_comb_ready", 32'(r0), 32'd1);
    v0 = 1'b1; d0 = 8'h42;
    tick();
    v0 = 1'b0;
    chk("s0_replace", 32'(od0), 32'h42);
    tick();
    chk("s0_drained", 32'(ov0), 32'd0);
    chk("s0_bubble_ctrl", 32'(oc0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
